// File: rtl/door_travel_model.sv
// rtl/door_travel_model.sv - door mechanism plant model driven by motor-up/down commands
// Integrates door position, generates limit switches, and traps illegal commands and limit overrun.
module door_travel_model #(
  parameter int TRAVEL   = 16,
  parameter int STEP_DIV = 4,
  parameter int POS_W    = 5,
  parameter int OVR_LIM  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             UP_M,
  input  logic             DN_M,
  input  logic             fault_clr,
  output logic             Up_Max,
  output logic             Dn_Max,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             fault
);

  localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int OV_W = $clog2(OVR_LIM + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DN    = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t state, next_state;

  logic [PS_W-1:0]  prescale, prescale_nxt, ps_base;
  logic [OV_W-1:0]  ovr_cnt, ovr_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             cmd_up, cmd_dn, cmd_both, cmd_none;
  logic             pushing, ovr_trip, step;
  logic             moving_nxt, fault_nxt;

  assign cmd_up   = UP_M & ~DN_M;
  assign cmd_dn   = DN_M & ~UP_M;
  assign cmd_both = UP_M & DN_M;
  assign cmd_none = ~UP_M & ~DN_M;

  // Driving into a limit that is already asserted counts toward an overrun fault.
  assign pushing  = ((state == S_UP) && Up_Max) || ((state == S_DN) && Dn_Max);
  assign ovr_trip = pushing && (ovr_cnt == OV_W'(OVR_LIM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (state == S_FAULT) begin
      if (fault_clr && cmd_none) begin
        next_state = S_IDLE;
      end
    end else if (ovr_trip || cmd_both) begin
      next_state = S_FAULT;
    end else if (cmd_up) begin
      next_state = S_UP;
    end else if (cmd_dn) begin
      next_state = S_DN;
    end else begin
      next_state = S_IDLE;
    end
  end

  always_comb begin
    moving_nxt = (next_state == S_UP) || (next_state == S_DN);
    fault_nxt  = (next_state == S_FAULT);
  end

  // The edge that enters (or reverses into) a travel state is cycle 1 of the step period.
  always_comb begin
    ps_base      = '0;
    prescale_nxt = '0;
    step         = 1'b0;
    if ((next_state == S_UP) || (next_state == S_DN)) begin
      ps_base = (next_state == state) ? prescale : '0;
      if (ps_base == PS_W'(STEP_DIV - 1)) begin
        prescale_nxt = '0;
        step         = 1'b1;
      end else begin
        prescale_nxt = ps_base + 1'b1;
      end
    end
  end

  always_comb begin
    pos_nxt = position;
    if (step) begin
      if ((next_state == S_UP) && (position != POS_W'(TRAVEL))) begin
        pos_nxt = position + 1'b1;
      end else if ((next_state == S_DN) && (position != '0)) begin
        pos_nxt = position - 1'b1;
      end
    end
  end

  always_comb begin
    ovr_nxt = '0;
    if ((next_state != S_FAULT) && pushing) begin
      ovr_nxt = ovr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position <= '0;
      prescale <= '0;
      ovr_cnt  <= '0;
      Up_Max   <= 1'b0;
      Dn_Max   <= 1'b1;
      moving   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      position <= pos_nxt;
      prescale <= prescale_nxt;
      ovr_cnt  <= ovr_nxt;
      Up_Max   <= (pos_nxt == POS_W'(TRAVEL));
      Dn_Max   <= (pos_nxt == '0);
      moving   <= moving_nxt;
      fault    <= fault_nxt;
    end
  end

endmodule

// File: doc/door_travel_model.md
Name: door_travel_model

Overview:
- Plant-side counterpart of the Moore door-motor controller FSM.
- Consumes the controller's motor commands (UP_M, DN_M) and integrates door position.
- Produces the limit-switch inputs the controller needs (Up_Max, Dn_Max).
- Used in closed-loop simulation and as an FPGA stand-in for the mechanism; flags illegal command combinations and overrun into a limit.

Parameters:
- TRAVEL, 16: position steps from fully closed (0) to fully open (TRAVEL); TRAVEL >= 2.
- STEP_DIV, 4: clock cycles per position step while the motor is driven; STEP_DIV >= 1.
- POS_W, 5: position width; TRAVEL < 2**POS_W is required.
- OVR_LIM, 8: consecutive cycles of driving into an asserted limit that raise a fault; OVR_LIM >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- UP_M  input  1  motor-up command from the controller.
- DN_M  input  1  motor-down command from the controller.
- fault_clr  input  1  synchronous request to leave FAULT.
- Up_Max  output  1  open limit switch; 1 when position == TRAVEL.
- Dn_Max  output  1  closed limit switch; 1 when position == 0.
- position  output  POS_W  current door position.
- moving  output  1  1 in state UP or DN.
- fault  output  1  1 in state FAULT.

Behaviour:
- Reset (async, rst=1): state=IDLE, position=0, prescale=0, ovr_cnt=0, Dn_Max=1, Up_Max=0, moving=0, fault=0.
- All outputs are registered. Up_Max and Dn_Max update on the same edge as position and always reflect the new position value.
- Command decode:
  - up = UP_M & ~DN_M
  - dn = DN_M & ~UP_M
  - both = UP_M & DN_M
  - none = neither asserted
- States: IDLE, UP, DN, FAULT. Priority each edge: both > up/dn > none.
  - IDLE: both -> FAULT; up -> UP; dn -> DN; none -> stay.
  - UP: both -> FAULT; dn -> DN; none -> IDLE; up -> stay.
  - DN: both -> FAULT; up -> UP; none -> IDLE; dn -> stay.
  - FAULT: stays until fault_clr=1 and none on the same edge, then -> IDLE. fault_clr with any command asserted is ignored.
- Prescaler:
  - Cleared on every state change, including direct UP<->DN reversal.
  - In UP/DN it increments each cycle.
  - When prescale == STEP_DIV-1 it wraps to 0 and a step occurs.
  - First step occurs STEP_DIV cycles after entering UP/DN, counting the entry edge as cycle 1.
- Step in UP: position+1, saturating at TRAVEL. Step in DN: position-1, saturating at 0. No wrap-around ever.
- Overrun counter (ovr_cnt):
  - Increments each cycle in UP with Up_Max=1, or in DN with Dn_Max=1.
  - Cleared otherwise.
  - When it reaches OVR_LIM, the next state is FAULT (takes precedence over the command decode).
- FAULT: position, Up_Max and Dn_Max frozen; moving=0; fault=1; prescale and ovr_cnt held at 0.
- rst mid-travel: immediate return to reset values; the door snaps to closed.

Test Plan (TRAVEL=16, STEP_DIV=4, OVR_LIM=8):
1. Reset then UP_M=1, DN_M=0 held:
   - Dn_Max falls and position=1 on the 4th rising edge after the command.
   - position=16 and Up_Max=1 on the 64th edge.
   - fault=1 on the 72nd edge (8 overrun cycles).
2. From position=16 with Up_Max=1, apply DN_M=1 for 8 edges, then none:
   - position=14, Up_Max=0, Dn_Max=0.
   - State IDLE, moving=0, position holds at 14.
3. UP_M=DN_M=1 for one cycle from IDLE at position=5:
   - fault=1 next edge; position stays 5.
   - fault_clr=1 with UP_M=1 -> remains FAULT.
   - fault_clr=1 with none -> IDLE, fault=0 next edge.
4. Reversal: UP for 6 edges (position=1, prescale=2), then DN_M only:
   - Prescaler restarts.
   - position=0 and Dn_Max=1 on the 4th edge after reversal, not earlier.
5. Closed loop with the controller FSM: Activate pulse from closed:
   - Door reaches Up_Max=1.
   - Controller drops UP_M within OVR_LIM cycles; fault stays 0.
6. rst asserted asynchronously mid-travel at position=9:
   - Outputs return to reset values before the next clock edge: position=0, Dn_Max=1, moving=0.
